// File: rtl/count_pulse_conditioner_pkg.sv
// Shared types and limits for the count-input conditioner.
// State encoding plus level/busy decode helpers used by the top.
package count_pulse_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } cpc_state_t;

    localparam int CPC_MIN_DEBOUNCE      = 2;
    localparam int CPC_MIN_REPEAT_PERIOD = 2;

    // The debounced level already reads high while a fall is still being qualified.
    function automatic logic cpc_level_of(cpc_state_t s);
        return (s == HIGH) || (s == FALL_CHK);
    endfunction

    function automatic logic cpc_busy_of(cpc_state_t s);
        return (s == RISE_CHK) || (s == FALL_CHK);
    endfunction

endpackage

// File: rtl/count_pulse_conditioner_if.sv
// Pad-side input and conditioned outputs of the count-input conditioner.
// master = the stage that drives the pad and consumes the pulses; slave = the conditioner.
interface count_pulse_conditioner_if;

    logic raw_in;
    logic count_pulse;
    logic level;
    logic busy;

    modport master (
        output raw_in,
        input  count_pulse,
        input  level,
        input  busy
    );

    modport slave (
        input  raw_in,
        output count_pulse,
        output level,
        output busy
    );

endinterface

// File: rtl/count_pulse_conditioner_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, async active-low reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/count_pulse_conditioner.sv
// Resynchronises, debounces and edge-detects an external count source into one-cycle pulses.
// Optional auto-repeat while held high is enabled by defining COUNT_PULSE_AUTO_REPEAT_EN.
module count_pulse_conditioner
    import count_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 200
) (
    input  logic                      clk,
    input  logic                      rst_n,
    count_pulse_conditioner_if.slave  bus
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < CPC_MIN_DEBOUNCE || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range 2..65535");
    end
    if (REPEAT_PERIOD < CPC_MIN_REPEAT_PERIOD || REPEAT_DELAY < CPC_MIN_REPEAT_PERIOD) begin : g_bad_repeat
        $error("REPEAT_PERIOD and REPEAT_DELAY must be at least 2");
    end

    logic       s2;
    cpc_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic       rise_ok;
    logic       pulse_nxt;
    logic       pulse_p1;
    logic       level_p1;
    logic       busy_p1;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.raw_in),
        .q     (s2)
    );

    // The counter is tested before incrementing and zeroed on every state entry, so it never wraps.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_ok   = 1'b0;
        case (state)
            LOW: begin
                if (s2) begin
                    state_nxt = RISE_CHK;
                    cnt_nxt   = '0;
                end
            end
            RISE_CHK: begin
                if (!s2) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    rise_ok   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!s2) begin
                    state_nxt = FALL_CHK;
                    cnt_nxt   = '0;
                end
            end
            FALL_CHK: begin
                if (s2) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef COUNT_PULSE_AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_periodic;
    logic             stay_high;
    logic             rpt_fire;

    // Any visit outside HIGH, including a fall bounce, restarts the initial delay.
    assign stay_high = (state == HIGH) && (state_nxt == HIGH);
    assign rpt_fire  = stay_high &&
                       (rpt_periodic ? (rpt_cnt == RPT_W'(REPEAT_PERIOD - 1))
                                     : (rpt_cnt == RPT_W'(REPEAT_DELAY - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b0;
        end else if (!stay_high) begin
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b0;
        end else if (rpt_fire) begin
            rpt_cnt      <= '0;
            rpt_periodic <= 1'b1;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end

    assign pulse_nxt = rise_ok | rpt_fire;
`else
    assign pulse_nxt = rise_ok;
`endif

    // Output registers are loaded from the next state so level and pulse move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_p1 <= 1'b0;
            level_p1 <= 1'b0;
            busy_p1  <= 1'b0;
        end else begin
            pulse_p1 <= pulse_nxt;
            level_p1 <= cpc_level_of(state_nxt);
            busy_p1  <= cpc_busy_of(state_nxt);
        end
    end

    assign bus.count_pulse = pulse_p1;
    assign bus.level       = level_p1;
    assign bus.busy        = busy_p1;

endmodule
